// File: rtl/mem_scheduler_pkg.sv
// Shared memory-interface types for the memory scheduler and its tag table.
package mem_scheduler_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BLOCK_W  = 64;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_TAGS = 16;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } REQ_OWNER;

  typedef struct packed {
    logic     valid;
    logic     prior;
    ADDR      addr;
    MEM_BLOCK data;
    logic     is_store;
  } MEM_REQ_PACKET;

  typedef struct packed {
    logic     valid;
    MEM_TAG   mem_tag;
    MEM_BLOCK data;
  } MEM_DATA_PACKET;

  // Which requester owns the memory port this cycle.
  typedef enum logic [1:0] {
    SelNone   = 2'h0,
    SelDcache = 2'h1,
    SelIcache = 2'h2
  } issue_sel_e;

  function automatic MEM_COMMAND req_command(input MEM_REQ_PACKET req);
    return req.is_store ? MEM_STORE : MEM_LOAD;
  endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Owner/valid table for in-flight load tags plus the outstanding-load counter.
// Allocation beats a same-cycle free of the same tag.
module mem_tag_table
  import mem_scheduler_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en,
  input  MEM_TAG   alloc_tag,
  input  REQ_OWNER alloc_owner,
  input  logic     free_en,
  input  MEM_TAG   free_tag,
  input  MEM_TAG   lookup_tag,
  output logic     lookup_hit,
  output REQ_OWNER lookup_owner,
  output logic [3:0] count
);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  REQ_OWNER            owner_q [NUM_TAGS];
  REQ_OWNER            owner_d [NUM_TAGS];
  logic [3:0]          count_q, count_d;

  // Lookup of the current table contents; tag 0 never hits.
  always_comb begin
    lookup_hit   = (lookup_tag != '0) && valid_q[lookup_tag];
    lookup_owner = owner_q[lookup_tag];
    count        = count_q;
  end

  // Next table state: free first, then allocate so allocation wins on a collision.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    count_d = count_q;
    if (free_en) begin
      valid_d[free_tag] = 1'b0;
    end
    if (alloc_en) begin
      valid_d[alloc_tag] = 1'b1;
      owner_d[alloc_tag] = alloc_owner;
    end
    if (alloc_en && !free_en && (count_q != 4'hF)) begin
      count_d = count_q + 4'd1;
    end else if (free_en && !alloc_en && (count_q != 4'h0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Table and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        owner_q[i] <= DCACHE;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_TAGS; i++) begin
        owner_q[i] <= owner_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates icache/dcache requests onto a single tagged memory port and routes
// returning load data back to the requester that owns the tag.
// Optional: define MEM_SCHED_AGING_EN to promote a starved icache after
// AGE_LIMIT consecutive dcache grants.
module mem_scheduler
  import mem_scheduler_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned AGE_LIMIT       = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  MEM_REQ_PACKET  dcache_req,
  output logic           dcache_req_accepted,
  input  MEM_REQ_PACKET  icache_req,
  output logic           icache_req_accepted,
  input  MEM_TAG         mem2proc_transaction_tag,
  input  MEM_TAG         mem2proc_data_tag,
  input  MEM_BLOCK       mem2proc_data,
  output MEM_COMMAND     proc2mem_command,
  output ADDR            proc2mem_addr,
  output MEM_BLOCK       proc2mem_data,
  output MEM_DATA_PACKET icache_resp,
  output MEM_DATA_PACKET dcache_resp,
  output logic [3:0]     outstanding_cnt,
  output logic           stray_tag_err
);

  issue_sel_e sel;
  logic       loads_full;
  logic       dcache_ok;
  logic       icache_ok;
  logic       age_promote;
  logic       alloc_en;
  REQ_OWNER   alloc_owner;
  logic       lookup_hit;
  REQ_OWNER   lookup_owner;
  logic       stray_q, stray_d;

  // Eligibility: loads are held back once the tag table is at capacity.
  always_comb begin
    loads_full = (outstanding_cnt >= 4'(MAX_OUTSTANDING));
    dcache_ok  = dcache_req.valid && (dcache_req.is_store || !loads_full);
    icache_ok  = icache_req.valid && (icache_req.is_store || !loads_full);
  end

`ifdef MEM_SCHED_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q, age_d;

  // Age tracks consecutive dcache wins over a waiting icache; saturates at the limit.
  always_comb begin
    age_d       = age_q;
    age_promote = (age_q == AGE_W'(AGE_LIMIT)) && icache_ok;
    if ((sel == SelIcache) || !icache_req.valid) begin
      age_d = '0;
    end else if ((sel == SelDcache) && (age_q != AGE_W'(AGE_LIMIT))) begin
      age_d = age_q + 1'b1;
    end
  end

  // Age register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Strict priority: no starvation relief.
  always_comb begin
    age_promote = 1'b0;
  end
`endif

  // Fixed-priority pick; nothing is issued while reset is held.
  always_comb begin
    sel = SelNone;
    if (age_promote) begin
      sel = SelIcache;
    end else if (dcache_ok && dcache_req.prior) begin
      sel = SelDcache;
    end else if (icache_ok && icache_req.prior) begin
      sel = SelIcache;
    end else if (dcache_ok) begin
      sel = SelDcache;
    end else if (icache_ok) begin
      sel = SelIcache;
    end
    if (!reset) begin
      sel = SelNone;
    end
  end

  // Drive the memory port; a requester is consumed only when memory returns a tag.
  always_comb begin
    proc2mem_command    = MEM_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    dcache_req_accepted = 1'b0;
    icache_req_accepted = 1'b0;
    unique case (sel)
      SelDcache: begin
        proc2mem_command    = req_command(dcache_req);
        proc2mem_addr       = dcache_req.addr;
        proc2mem_data       = dcache_req.data;
        dcache_req_accepted = (mem2proc_transaction_tag != '0);
      end
      SelIcache: begin
        proc2mem_command    = req_command(icache_req);
        proc2mem_addr       = icache_req.addr;
        proc2mem_data       = icache_req.data;
        icache_req_accepted = (mem2proc_transaction_tag != '0);
      end
      default: ;
    endcase
  end

  // Only accepted loads occupy a tag.
  always_comb begin
    alloc_en    = (dcache_req_accepted && !dcache_req.is_store) ||
                  (icache_req_accepted && !icache_req.is_store);
    alloc_owner = icache_req_accepted ? ICACHE : DCACHE;
  end

  mem_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_transaction_tag),
    .alloc_owner  (alloc_owner),
    .free_en      (lookup_hit),
    .free_tag     (mem2proc_data_tag),
    .lookup_tag   (mem2proc_data_tag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .count        (outstanding_cnt)
  );

  // Route returning data to the tag's owner; responses are idle-zero when invalid.
  always_comb begin
    icache_resp = '0;
    dcache_resp = '0;
    if (reset && lookup_hit) begin
      if (lookup_owner == ICACHE) begin
        icache_resp.valid   = 1'b1;
        icache_resp.mem_tag = mem2proc_data_tag;
        icache_resp.data    = mem2proc_data;
      end else begin
        dcache_resp.valid   = 1'b1;
        dcache_resp.mem_tag = mem2proc_data_tag;
        dcache_resp.data    = mem2proc_data;
      end
    end
  end

  // Sticky error for data returned on a tag nobody owns.
  always_comb begin
    stray_d       = stray_q || ((mem2proc_data_tag != '0) && !lookup_hit);
    stray_tag_err = stray_q;
  end

  // Stray-tag flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stray_q <= 1'b0;
    end else begin
      stray_q <= stray_d;
    end
  end

endmodule
